// File: rtl/intf_me.sv
// rtl/intf_me.sv - full-search 16x16 block-matching motion estimator
//
// Purpose : finds the minimum-SAD displacement (dx,dy in -8..+7) of a 16x16
//           reference block inside a 32x32 search window.
// Ports   : clock    - system clock, rising edge
//           reset_n  - asynchronous active-low reset
//           start    - level; high runs/holds the search, low idles/clears
//           BestDist - saturated minimum SAD (0xFF = nothing below 255)
//           motionX  - two's-complement dx of the best candidate
//           motionY  - two's-complement dy of the best candidate

module intf_me_memr #(
  parameter int PIX_W = 8,
  parameter int DEPTH = 256
) (
  input  logic                     clock,
  input  logic [$clog2(DEPTH)-1:0] i_addr,
  output logic [PIX_W-1:0]         o_data
);
  // Contents are loaded by backdoor; the register only holds them.
  logic [PIX_W-1:0] Rmem [0:DEPTH-1];

  always_ff @(posedge clock) Rmem <= Rmem;

  assign o_data = Rmem[i_addr];
endmodule

module intf_me_mems #(
  parameter int PIX_W = 8,
  parameter int DEPTH = 1024,
  parameter int NRD   = 16
) (
  input  logic                     clock,
  input  logic [$clog2(DEPTH)-1:0] i_addr [NRD],
  output logic [PIX_W-1:0]         o_data [NRD]
);
  // Contents are loaded by backdoor; the register only holds them.
  logic [PIX_W-1:0] Smem [0:DEPTH-1];

  always_ff @(posedge clock) Smem <= Smem;

  always_comb begin
    for (int i = 0; i < NRD; i++) o_data[i] = Smem[i_addr[i]];
  end
endmodule

module intf_me_ctl (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic [12:0] count
);
  localparam logic [12:0] LAST = 13'd4111;

  logic [12:0] r_count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)              r_count <= '0;
    else if (!start)           r_count <= '0;
    else if (r_count != LAST)  r_count <= r_count + 13'd1;
  end

  assign count = r_count;
endmodule

module intf_me_comp (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        i_init,
  input  logic        i_valid,
  input  logic [15:0] i_sad,
  input  logic [3:0]  i_dx_idx,
  input  logic [3:0]  i_dy_idx,
  output logic [7:0]  o_best_dist,
  output logic [3:0]  o_motion_x,
  output logic [3:0]  o_motion_y,
  output logic        newBest
);
  logic [15:0] r_best;
  logic [7:0]  r_best_dist;
  logic [3:0]  r_mx, r_my;
  logic        r_new_best;
  logic        w_win;

  // Strictly-smaller only: on a tie the earlier candidate is kept.
  assign w_win = i_valid & (i_sad < r_best);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_best      <= '1;
      r_best_dist <= 8'hFF;
      r_mx        <= '0;
      r_my        <= '0;
      r_new_best  <= 1'b0;
    end else begin
      r_new_best <= w_win;
      if (i_init) begin
        r_best <= '1;
      end else if (w_win) begin
        r_best      <= i_sad;
        r_best_dist <= (|i_sad[15:8]) ? 8'hFF : i_sad[7:0];
        // index 0..15 maps to -8..+7: flipping the MSB gives two's complement
        r_mx        <= i_dx_idx ^ 4'h8;
        r_my        <= i_dy_idx ^ 4'h8;
      end
    end
  end

  assign o_best_dist = r_best_dist;
  assign o_motion_x  = r_mx;
  assign o_motion_y  = r_my;
  assign newBest     = r_new_best;
endmodule

module intf_me #(
  parameter int BLK   = 16,
  parameter int WIN   = 32,
  parameter int PIX_W = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  output logic [7:0] BestDist,
  output logic [3:0] motionX,
  output logic [3:0] motionY
);
  logic [12:0]      w_count;
  logic             r_start_q;
  logic [PIX_W-1:0] w_rpix;
  logic [9:0]       w_saddr [BLK];
  logic [PIX_W-1:0] w_spix  [BLK];
  logic [PIX_W-1:0] w_diff  [BLK];
  logic [15:0]      r_acc   [BLK];
  logic [15:0]      r_sad   [BLK];
  logic [3:0]       w_pass, w_row, w_col;
  logic [4:0]       w_cmp_pass;
  logic             w_compute, w_pass_end, w_cmp_valid, w_run_init;
  logic             w_new_best;
  logic             w_unused_new_best;

  // count = pass*256 + row*16 + col during the 4096 compute cycles; the
  // 16 cycles after a pass ends compare that pass's SADs one per cycle.
  assign w_pass      = w_count[11:8];
  assign w_row       = w_count[7:4];
  assign w_col       = w_count[3:0];
  assign w_compute   = start & ~w_count[12];
  assign w_pass_end  = w_compute & (w_count[7:0] == 8'hFF);
  assign w_cmp_valid = start & (w_count[12:8] != 5'd0) & (w_count[7:4] == 4'd0);
  assign w_cmp_pass  = w_count[12:8] - 5'd1;
  assign w_run_init  = start & ~r_start_q;

  intf_me_ctl ctl_u (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start),
    .count   (w_count)
  );

  intf_me_memr #(.PIX_W(PIX_W), .DEPTH(BLK*BLK)) memR_u (
    .clock  (clock),
    .i_addr (w_count[7:0]),
    .o_data (w_rpix)
  );

  intf_me_mems #(.PIX_W(PIX_W), .DEPTH(WIN*WIN), .NRD(BLK)) memS_u (
    .clock  (clock),
    .i_addr (w_saddr),
    .o_data (w_spix)
  );

  // PE j (dx=j-8) reads window pixel (row+pass, col+j) for the current
  // reference pixel; the +8 offsets cancel against dx/dy = idx-8.
  always_comb begin
    for (int j = 0; j < BLK; j++) begin
      w_saddr[j] = {({1'b0, w_row} + {1'b0, w_pass}), ({1'b0, w_col} + 5'(j))};
      w_diff[j]  = (w_rpix >= w_spix[j]) ? (w_rpix - w_spix[j]) : (w_spix[j] - w_rpix);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_start_q <= 1'b0;
      for (int j = 0; j < BLK; j++) begin
        r_acc[j] <= '0;
        r_sad[j] <= '0;
      end
    end else begin
      r_start_q <= start;
      for (int j = 0; j < BLK; j++) begin
        if (!start) begin
          r_acc[j] <= '0;
        end else if (w_pass_end) begin
          // hand the finished SAD to the compare bank while the next pass
          // starts from zero
          r_acc[j] <= '0;
          r_sad[j] <= r_acc[j] + 16'(w_diff[j]);
        end else if (w_compute) begin
          r_acc[j] <= r_acc[j] + 16'(w_diff[j]);
        end
      end
    end
  end

  intf_me_comp comp_u (
    .clock       (clock),
    .reset_n     (reset_n),
    .i_init      (w_run_init),
    .i_valid     (w_cmp_valid),
    .i_sad       (r_sad[w_count[3:0]]),
    .i_dx_idx    (w_count[3:0]),
    .i_dy_idx    (w_cmp_pass[3:0]),
    .o_best_dist (BestDist),
    .o_motion_x  (motionX),
    .o_motion_y  (motionY),
    .newBest     (w_new_best)
  );

  // newBest is an observation point only; nothing downstream consumes it.
  assign w_unused_new_best = w_new_best;
endmodule

// File: tb/tb_intf_me.sv
// tb/tb_intf_me.sv - randomized self-checking bench for intf_me
module tb_intf_me;
  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  logic       start = 1'b0;
  logic [7:0] BestDist;
  logic [3:0] motionX, motionY;

  int total = 0;
  int bad = 0;
  int pulses = 0;
  bit chk_en = 1'b0;
  int exp_bd, exp_mx, exp_my, exp_pulses;
  logic [7:0] rm [256];
  logic [7:0] sm [1024];

  always #5 clock = ~clock;

  intf_me dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .BestDist (BestDist),
    .motionX  (motionX),
    .motionY  (motionY)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference: every candidate in ascending (dy,dx) order, strict-less wins.
  task automatic model();
    int best, sad, d;
    best = 65535; exp_pulses = 0; exp_mx = 0; exp_my = 0;
    for (int dy = -8; dy < 8; dy++) begin
      for (int dx = -8; dx < 8; dx++) begin
        sad = 0;
        for (int r = 0; r < 16; r++)
          for (int c = 0; c < 16; c++) begin
            d = int'(rm[r*16+c]) - int'(sm[(r+8+dy)*32 + c+8+dx]);
            sad += (d < 0) ? -d : d;
          end
        if (sad < best) begin
          best = sad; exp_mx = dx & 15; exp_my = dy & 15; exp_pulses++;
        end
      end
    end
    exp_bd = (best > 255) ? 255 : best;
  endtask

  task automatic load();
    for (int i = 0; i < 256; i++)  dut.memR_u.Rmem[i] = rm[i];
    for (int i = 0; i < 1024; i++) dut.memS_u.Smem[i] = sm[i];
  endtask

  task automatic rand_s();
    for (int i = 0; i < 1024; i++) sm[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic rand_r();
    for (int i = 0; i < 256; i++) rm[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic cut(input int dx, input int dy);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        rm[r*16+c] = sm[(r+8+dy)*32 + c+8+dx];
  endtask

  task automatic fill(input logic [7:0] rv, input logic [7:0] sv);
    for (int i = 0; i < 256; i++)  rm[i] = rv;
    for (int i = 0; i < 1024; i++) sm[i] = sv;
  endtask

  task automatic run_check(input string tag);
    model();
    load();
    @(negedge clock);
    pulses = 0;
    start = 1'b1;
    repeat (4112) @(posedge clock);
    @(negedge clock);
    chk({tag, " count"},    int'(dut.ctl_u.count), 4111);
    chk({tag, " BestDist"}, int'(BestDist), exp_bd);
    chk({tag, " motionX"},  int'(motionX), exp_mx);
    chk({tag, " motionY"},  int'(motionY), exp_my);
    chk({tag, " pulses"},   pulses, exp_pulses);
    start = 1'b0;
  endtask

  task automatic hold_check(input string tag);
    chk_en = 1'b1;
    repeat (4) @(negedge clock);
    chk_en = 1'b0;
    chk({tag, " idle count"}, int'(dut.ctl_u.count), 0);
  endtask

  // Count newBest high cycles; a wide pulse inflates the count.
  always begin
    @(posedge clock);
    #1;
    if (dut.comp_u.newBest === 1'b1) pulses++;
  end

  // Outputs must hold the finished result while start is low.
  always @(negedge clock) begin
    if (chk_en)
      chk("hold outputs", int'({BestDist, motionX, motionY}),
          (exp_bd << 8) | (exp_mx << 4) | exp_my);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    fill(8'h00, 8'h00);
    #1 reset_n = 1'b0;
    #2;
    chk("reset BestDist", int'(BestDist), 255);
    chk("reset motion",   int'({motionX, motionY}), 0);
    chk("reset count",    int'(dut.ctl_u.count), 0);
    chk("reset newBest",  int'(dut.comp_u.newBest), 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    rand_s(); cut(3, -5);
    run_check("cut(+3,-5)");
    chk("model cut(+3,-5)", (exp_bd << 8) | (exp_mx << 4) | exp_my, 'h03B);
    hold_check("cut(+3,-5)");

    rand_s(); cut(-8, -8);
    run_check("corner(-8,-8)");
    chk("model corner(-8,-8)", (exp_bd << 8) | (exp_mx << 4) | exp_my, 'h088);
    hold_check("corner(-8,-8)");

    rand_s(); cut(7, 7);
    run_check("corner(+7,+7)");
    chk("model corner(+7,+7)", (exp_bd << 8) | (exp_mx << 4) | exp_my, 'h077);
    hold_check("corner(+7,+7)");

    fill(8'h00, 8'hFF);
    run_check("all-max");
    chk("model all-max", (exp_bd << 8) | (exp_mx << 4) | exp_my, 'hFF88);
    chk("model all-max pulses", exp_pulses, 1);
    hold_check("all-max");

    fill(8'h10, 8'h10);
    run_check("all-tie");
    chk("model all-tie", (exp_bd << 8) | (exp_mx << 4) | exp_my, 'h088);
    chk("model all-tie pulses", exp_pulses, 1);
    hold_check("all-tie");

    for (int n = 0; n < 2; n++) begin
      rand_s(); rand_r();
      run_check("random");
      hold_check("random");
    end

    rand_s(); cut(-4, 2);
    load();
    @(negedge clock);
    start = 1'b1;
    repeat (2000) @(posedge clock);
    #2 reset_n = 1'b0;
    start = 1'b0;
    #1;
    chk("midreset BestDist", int'(BestDist), 255);
    chk("midreset motion",   int'({motionX, motionY}), 0);
    chk("midreset count",    int'(dut.ctl_u.count), 0);
    chk("midreset newBest",  int'(dut.comp_u.newBest), 0);
    @(negedge clock);
    reset_n = 1'b1;
    run_check("after reset");
    chk("model after reset", (exp_bd << 8) | (exp_mx << 4) | exp_my, 'h0C2);
    hold_check("after reset");

    rand_s(); cut(-2, 4);
    run_check("b2b first");
    cut(5, -7);
    run_check("b2b second");
    chk("model b2b second", (exp_bd << 8) | (exp_mx << 4) | exp_my, 'h059);
    hold_check("b2b second");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
